// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter shared by the pipeline WB stage and the MDU.
// It also keeps a scoreboard of outstanding MDU destinations for the decode RAW stall.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_wb_stall,
  input  logic            i_mdu_issue,
  input  logic [4:0]      i_mdu_issue_rd,
  input  logic            i_mdu_valid,
  input  logic [4:0]      i_mdu_rd,
  input  logic [XLEN-1:0] i_mdu_data,
  output logic            o_mdu_ready,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic            o_raw_stall,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic [31:0]     o_pending
);

  localparam int unsigned CntW = $clog2(MAX_STARVE + 1);

  logic [31:0]     pending_q, pending_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic            wb_req, mdu_req, grant_wb, grant_mdu, mdu_xfer;
  logic [31:0]     set_vec, clr_vec;

  always_comb begin
    wb_req    = i_wb_valid && (i_wb_rd != 5'd0);
    mdu_req   = i_mdu_valid && (i_mdu_rd != 5'd0);
    grant_wb  = 1'b0;
    grant_mdu = 1'b0;
    starve_d  = starve_q;
    if (wb_req && mdu_req) begin
      // MDU has lost MAX_STARVE conflicts in a row: it takes the port now
      if (starve_q >= CntW'(MAX_STARVE)) begin
        grant_mdu = 1'b1;
        starve_d  = '0;
      end else begin
        grant_wb = 1'b1;
        starve_d = starve_q + 1'b1;
      end
    end else if (wb_req) begin
      grant_wb = 1'b1;
    end else if (mdu_req) begin
      grant_mdu = 1'b1;
      starve_d  = '0;
    end
  end

  always_comb begin
    o_wb_stall  = 1'b0;
    o_mdu_ready = 1'b0;
    o_raw_stall = 1'b0;
    o_rd_wren   = 1'b0;
    o_rd_addr   = 5'd0;
    o_rd_data   = '0;
    if (!i_reset) begin
      o_wb_stall  = wb_req && !grant_wb;
      // An x0 result is retired without using the port
      o_mdu_ready = grant_mdu || (i_mdu_valid && (i_mdu_rd == 5'd0));
      o_raw_stall = pending_q[i_rs1_addr] | pending_q[i_rs2_addr];
      o_rd_wren   = grant_wb || grant_mdu;
      if (grant_wb) begin
        o_rd_addr = i_wb_rd;
        o_rd_data = i_wb_data;
      end else if (grant_mdu) begin
        o_rd_addr = i_mdu_rd;
        o_rd_data = i_mdu_data;
      end
    end
  end

  always_comb begin
    mdu_xfer  = i_mdu_valid && o_mdu_ready;
    set_vec   = i_mdu_issue ? (32'd1 << i_mdu_issue_rd) : 32'd0;
    clr_vec   = mdu_xfer ? (32'd1 << i_mdu_rd) : 32'd0;
    // Set is applied after clear so a same-cycle reissue stays pending
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  assign o_pending = pending_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pending_q <= '0;
      starve_q  <= '0;
    end else begin
      pending_q <= pending_d;
      starve_q  <= starve_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural model of the
// write-port arbitration and the MDU scoreboard.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned MAX_STARVE = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_stall;
  logic            mdu_issue;
  logic [4:0]      mdu_issue_rd;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic [4:0]      rs1_addr, rs2_addr;
  logic            raw_stall;
  logic            rd_wren;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     pending;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [31:0] m_pend = '0;
  int          m_cnt = 0;
  bit          last_rdy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN      (XLEN),
    .MAX_STARVE(MAX_STARVE)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_wb_valid    (wb_valid),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data),
    .o_wb_stall    (wb_stall),
    .i_mdu_issue   (mdu_issue),
    .i_mdu_issue_rd(mdu_issue_rd),
    .i_mdu_valid   (mdu_valid),
    .i_mdu_rd      (mdu_rd),
    .i_mdu_data    (mdu_data),
    .o_mdu_ready   (mdu_ready),
    .i_rs1_addr    (rs1_addr),
    .i_rs2_addr    (rs2_addr),
    .o_raw_stall   (raw_stall),
    .o_rd_wren     (rd_wren),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_pending     (pending)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock: evaluate model and compare at negedge, then advance past posedge
  task automatic step();
    bit          wq, mq, e_wren, e_wbst, e_rdy, e_raw;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    int          ncnt;
    @(negedge clk);
    wq = wb_valid && (wb_rd != 0);
    mq = mdu_valid && (mdu_rd != 0);
    e_wren = 0; e_wbst = 0; e_rdy = 0; e_raw = 0; e_addr = 0; e_data = 0;
    ncnt = m_cnt;
    if (!reset) begin
      if (wq && mq && m_cnt == MAX_STARVE) begin
        e_wren = 1; e_addr = mdu_rd; e_data = mdu_data; e_rdy = 1; e_wbst = 1; ncnt = 0;
      end else if (wq) begin
        e_wren = 1; e_addr = wb_rd; e_data = wb_data;
        if (mq) ncnt = m_cnt + 1;
      end else if (mq) begin
        e_wren = 1; e_addr = mdu_rd; e_data = mdu_data; e_rdy = 1; ncnt = 0;
      end
      if (mdu_valid && mdu_rd == 0) e_rdy = 1;
      e_raw = m_pend[rs1_addr] || m_pend[rs2_addr];
    end
    check("rd_wren", 64'(rd_wren), 64'(e_wren));
    check("rd_addr", 64'(rd_addr), 64'(e_addr));
    check("rd_data", 64'(rd_data), 64'(e_data));
    check("wb_stall", 64'(wb_stall), 64'(e_wbst));
    check("mdu_ready", 64'(mdu_ready), 64'(e_rdy));
    check("raw_stall", 64'(raw_stall), 64'(e_raw));
    check("pending", 64'(pending), 64'(m_pend));
    if (reset) begin
      m_pend = '0;
      m_cnt  = 0;
    end else begin
      if (mdu_valid && e_rdy) m_pend[mdu_rd] = 1'b0;
      if (mdu_issue && mdu_issue_rd != 0) m_pend[mdu_issue_rd] = 1'b1;
      m_cnt = ncnt;
    end
    last_rdy = mdu_valid && e_rdy && !reset;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  initial begin
    logic [4:0] r;
    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    // WB only
    wb_valid = 1; wb_rd = 5; wb_data = 32'h11;
    step();
    idle();

    // Starvation bound: WB wins four conflicts, MDU wins the fifth
    mdu_issue = 1; mdu_issue_rd = 7;
    step();
    idle();
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hABCD;
    wb_valid = 1; wb_rd = 2;
    for (int i = 0; i < 7; i++) begin
      wb_data = $urandom;
      step();
      if (last_rdy) mdu_valid = 0;
    end
    idle();

    // RAW stall through the MDU write cycle, then same-cycle reissue keeps x9 pending
    mdu_issue = 1; mdu_issue_rd = 9; rs1_addr = 9;
    step();
    mdu_issue = 0;
    step();
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    step();
    mdu_valid = 0;
    step();
    mdu_issue = 1; mdu_issue_rd = 9;
    step();
    mdu_issue = 0; mdu_valid = 1; mdu_rd = 9; mdu_issue = 1; mdu_issue_rd = 9;
    step();
    idle(); rs1_addr = 9;
    step();

    // x0 handling
    mdu_issue = 1; mdu_issue_rd = 0;
    step();
    idle();
    mdu_valid = 1; mdu_rd = 0; wb_valid = 1; wb_rd = 3; wb_data = 32'h33;
    step();
    idle();

    // Reset mid-operation with pending x3 and a partly starved MDU
    mdu_issue = 1; mdu_issue_rd = 3;
    step();
    idle();
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h3; wb_valid = 1; wb_rd = 4;
    step();
    step();
    reset = 1;
    step();
    idle();
    wb_valid = 1; wb_rd = 4; mdu_valid = 1; mdu_rd = 0;
    step();
    idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(99, 0) == 0);
      if (!mdu_valid && $urandom_range(2, 0) == 0) begin
        if ($urandom_range(9, 0) == 0) begin
          mdu_valid = 1; mdu_rd = 0; mdu_data = $urandom;
        end else if (m_pend != 0) begin
          do r = 5'($urandom_range(31, 0)); while (!m_pend[r]);
          mdu_valid = 1; mdu_rd = r; mdu_data = $urandom;
        end
      end
      wb_valid = ($urandom_range(9, 0) < 8);
      do r = 5'($urandom_range(31, 0)); while (m_pend[r]);
      wb_rd = r;
      wb_data = $urandom;
      mdu_issue = ($urandom_range(3, 0) == 0);
      mdu_issue_rd = 5'($urandom_range(31, 0));
      rs1_addr = 5'($urandom_range(31, 0));
      rs2_addr = 5'($urandom_range(31, 0));
      step();
      if (last_rdy || reset) mdu_valid = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
